branch_hazard_unit: RTL and testbench



---
 rtl/branch_hazard_unit.sv | 111 +++++++++++
 tb/tb_branch_hazard_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_unit.sv
// branch_hazard_unit
// Stall/flush control for the ID-stage branch comparator and the ID/EX
// load-use path. Shadow slots track the writeback intent of the
// instructions in EX (_p1) and MEM (_p2).
// Optional feature: define BRANCH_HAZARD_PERF_CNT_EN to build a saturating
// stall-cycle counter on stall_cnt_o; otherwise stall_cnt_o is tied to 0.
module branch_hazard_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic        id_is_branch_i,
  input  logic [4:0]  id_rs_addr_i,
  input  logic [4:0]  id_rt_addr_i,
  input  logic        id_uses_rt_i,
  input  logic        id_reg_write_i,
  input  logic        id_mem_read_i,
  input  logic [4:0]  id_write_addr_i,
  input  logic        branch_taken_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] stall_cnt_o
);

  // EX shadow slot
  logic       ex_vld_p1;
  logic       ex_rw_p1;
  logic       ex_mr_p1;
  logic [4:0] ex_addr_p1;
  // MEM shadow slot
  logic       mem_vld_p2;
  logic       mem_rw_p2;
  logic       mem_mr_p2;
  logic [4:0] mem_addr_p2;

  logic ex_wr_rs, ex_wr_rt, mem_wr_rs, mem_wr_rt;
  logic haz_rs, haz_rt, rt_read;

  // A slot produces r when it is a live writer of a non-zero register
  function automatic logic writes_reg(input logic vld, input logic rw,
                                      input logic [4:0] addr, input logic [4:0] r);
    return vld & rw & (addr == r) & (r != 5'd0);
  endfunction

  assign ex_wr_rs  = writes_reg(ex_vld_p1,  ex_rw_p1,  ex_addr_p1,  id_rs_addr_i);
  assign ex_wr_rt  = writes_reg(ex_vld_p1,  ex_rw_p1,  ex_addr_p1,  id_rt_addr_i);
  assign mem_wr_rs = writes_reg(mem_vld_p2, mem_rw_p2, mem_addr_p2, id_rs_addr_i);
  assign mem_wr_rt = writes_reg(mem_vld_p2, mem_rw_p2, mem_addr_p2, id_rt_addr_i);

  // Branch needs the value at the start of ID: nothing from EX, no load from MEM.
  // Any consumer of a load sitting in EX must wait (load-use).
  assign haz_rs = (id_is_branch_i & ex_wr_rs)
                | (id_is_branch_i & mem_wr_rs & mem_mr_p2)
                | (ex_wr_rs & ex_mr_p1);
  assign haz_rt = (id_is_branch_i & ex_wr_rt)
                | (id_is_branch_i & mem_wr_rt & mem_mr_p2)
                | (ex_wr_rt & ex_mr_p1);

  assign rt_read = id_uses_rt_i | id_is_branch_i;

  // Both operand hazards fold into one stall; stale operands suppress the flush
  always_comb begin
    stall_o = id_valid_i & (haz_rs | (rt_read & haz_rt));
    flush_o = id_valid_i & id_is_branch_i & branch_taken_i & ~stall_o;
  end

  // Slot control: a stall or empty ID becomes a bubble in EX; MEM follows EX
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_vld_p1  <= 1'b0;
      ex_rw_p1   <= 1'b0;
      ex_mr_p1   <= 1'b0;
      mem_vld_p2 <= 1'b0;
      mem_rw_p2  <= 1'b0;
      mem_mr_p2  <= 1'b0;
    end else begin
      ex_vld_p1  <= id_valid_i & ~stall_o;
      ex_rw_p1   <= id_reg_write_i;
      ex_mr_p1   <= id_mem_read_i;
      mem_vld_p2 <= ex_vld_p1;
      mem_rw_p2  <= ex_rw_p1;
      mem_mr_p2  <= ex_mr_p1;
    end
  end

  // Slot destination addresses; only meaningful while the valid bit is set
  always_ff @(posedge clk_i) begin
    ex_addr_p1  <= id_write_addr_i;
    mem_addr_p2 <= ex_addr_p1;
  end

`ifdef BRANCH_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_p1;

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // Count stalled cycles, holding at full scale
  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt_p1 <= 32'd0;
    else if (stall_o)
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
  end

  assign stall_cnt_o = stall_cnt_p1;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Scoreboard bench for branch_hazard_unit: the driver pushes the expected
// {stall, flush, count} from a producer-age model; a negedge monitor compares.
module tb_branch_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic        id_is_branch_i;
  logic [4:0]  id_rs_addr_i;
  logic [4:0]  id_rt_addr_i;
  logic        id_uses_rt_i;
  logic        id_reg_write_i;
  logic        id_mem_read_i;
  logic [4:0]  id_write_addr_i;
  logic        branch_taken_i;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] stall_cnt_o;

  always #5 clk = ~clk;

  branch_hazard_unit dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_is_branch_i (id_is_branch_i),
    .id_rs_addr_i   (id_rs_addr_i),
    .id_rt_addr_i   (id_rt_addr_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .id_reg_write_i (id_reg_write_i),
    .id_mem_read_i  (id_mem_read_i),
    .id_write_addr_i(id_write_addr_i),
    .branch_taken_i (branch_taken_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic [4:0] a;
  } op_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic [31:0] cnt;
  } exp_t;

  op_t         flight[$];   // [0] issued last cycle (age 1), [1] age 2
  exp_t        exp_q[$];
  logic [31:0] model_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  int          stall_seen = 0;
  int          flush_seen = 0;
  bit          cur_stall;
  int          s0, f0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    flight.delete();
    flight.push_back('0);
    flight.push_back('0);
    model_cnt = 32'd0;
  endtask

  // A result becomes usable once its producer is old enough: one cycle for an
  // ALU result consumed in EX, plus one if it comes from a load, plus one if
  // the consumer compares in ID.
  function automatic bit blocked(input logic [4:0] r, input bit br);
    op_t p;
    int  need;
    for (int a = 0; a < 2; a++) begin
      p = flight[a];
      need = 1 + int'(p.mr) + int'(br);
      if (r != 5'd0 && p.v && p.rw && p.a == r && (a + 1) < need) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic step(input bit r, input bit v, input bit br,
                      input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                      input bit rw, input bit mr, input logic [4:0] wa, input bit tk);
    exp_t e;
    bit   st;
    op_t  o;
    rst_i = r; id_valid_i = v; id_is_branch_i = br;
    id_rs_addr_i = rs; id_rt_addr_i = rt; id_uses_rt_i = urt;
    id_reg_write_i = rw; id_mem_read_i = mr; id_write_addr_i = wa;
    branch_taken_i = tk;
    st = v && (blocked(rs, br) || ((urt || br) && blocked(rt, br)));
    e.stall = st;
    e.flush = v && br && tk && !st;
`ifdef BRANCH_HAZARD_PERF_CNT_EN
    e.cnt = model_cnt;
`else
    e.cnt = 32'd0;
`endif
    exp_q.push_back(e);
    cur_stall = st;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (st && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
      o.v = v && !st; o.rw = rw; o.mr = mr; o.a = wa;
      void'(flight.pop_back());
      flight.push_front(o);
    end
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
  endtask

  task automatic alu(input logic [4:0] wa);
    step(0, 1, 0, 5'd1, 5'd2, 1, 1, 0, wa, 0);
  endtask

  task automatic ld(input logic [4:0] wa);
    step(0, 1, 0, 5'd1, 5'd0, 0, 1, 1, wa, 0);
  endtask

  // Hold the branch in ID until it is no longer stalled (bounded)
  task automatic hold_branch(input logic [4:0] rs, input logic [4:0] rt, input bit tk);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, rs, rt, 0, 0, 0, 5'd0, tk);
      if (!cur_stall) break;
    end
  endtask

  // Monitor: the DUT presents a decision every cycle while ID is driven
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (stall_o === 1'b1) stall_seen++;
      if (flush_o === 1'b1) flush_seen++;
      check("stall", {31'd0, stall_o}, {31'd0, e.stall});
      check("flush", {31'd0, flush_o}, {31'd0, e.flush});
      check("stall_cnt", stall_cnt_o, e.cnt);
    end
  end

  initial begin
    bit          hold;
    logic [4:0]  rs, rt, wa;
    bit          br, urt, rw, mr, v;

    model_reset();
    rst_i = 1'b1; id_valid_i = 0; id_is_branch_i = 0; id_rs_addr_i = 0;
    id_rt_addr_i = 0; id_uses_rt_i = 0; id_reg_write_i = 0; id_mem_read_i = 0;
    id_write_addr_i = 0; branch_taken_i = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    nop(1);

    // branch on ALU result in EX
    s0 = stall_seen; alu(5'd3); hold_branch(5'd3, 5'd4, 0);
    check("alu_beq_len", stall_seen - s0, 1);
    nop(2);

    // branch on load in EX, then MEM
    s0 = stall_seen; ld(5'd5); hold_branch(5'd1, 5'd5, 0);
    check("lw_bne_len", stall_seen - s0, 2);
    nop(2);

    // load-use, rs then rt
    s0 = stall_seen; ld(5'd7);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 5'd7, 5'd1, 0, 1, 0, 5'd2, 0);
      if (!cur_stall) break;
    end
    check("lw_use_rs_len", stall_seen - s0, 1);
    nop(2);
    s0 = stall_seen; ld(5'd7);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 5'd1, 5'd7, 1, 1, 0, 5'd2, 0);
      if (!cur_stall) break;
    end
    check("lw_use_rt_len", stall_seen - s0, 1);
    nop(2);

    // no-hazard cases
    s0 = stall_seen;
    alu(5'd0); hold_branch(5'd0, 5'd0, 0);
    nop(2);
    alu(5'd3); alu(5'd9); hold_branch(5'd3, 5'd3, 0);
    nop(2);
    alu(5'd3); alu(5'd9); alu(5'd10); hold_branch(5'd3, 5'd3, 0);
    check("no_hazard_len", stall_seen - s0, 0);
    nop(2);

    // taken branch, clean then stalled
    f0 = flush_seen; hold_branch(5'd1, 5'd2, 1);
    check("taken_flush", flush_seen - f0, 1);
    nop(2);
    f0 = flush_seen; s0 = stall_seen; alu(5'd3); hold_branch(5'd3, 5'd3, 1);
    check("stalled_taken_flush", flush_seen - f0, 1);
    check("stalled_taken_len", stall_seen - s0, 1);
    nop(2);

    // reset in the first stall cycle
    ld(5'd5);
    step(1, 1, 1, 5'd5, 5'd5, 0, 0, 0, 5'd0, 0);
    step(0, 1, 1, 5'd5, 5'd5, 0, 0, 0, 5'd0, 0);
    check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    check("rst_cnt", stall_cnt_o, 32'd0);
    nop(2);

    // randomized traffic; a stalled instruction is held in ID
    hold = 0; rs = 0; rt = 0; wa = 0; br = 0; urt = 0; rw = 0; mr = 0; v = 0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        v   = ($urandom_range(0, 5) != 0);
        br  = ($urandom_range(0, 2) == 0);
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        urt = $urandom_range(0, 1);
        rw  = br ? 1'b0 : 1'($urandom_range(0, 1));
        mr  = rw && ($urandom_range(0, 1) == 1);
        wa  = 5'($urandom_range(0, 3));
      end
      step(($urandom_range(0, 39) == 0), v, br, rs, rt, urt, rw, mr, wa,
           1'($urandom_range(0, 1)));
      hold = cur_stall;
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
